// File: rtl/joy_db15.sv
// Device-side DB15 joystick responder: emulates the adapter's PISO shift chain,
// answering host JOY_LOAD/JOY_CLK strobes with both players' buttons on JOY_DATA.
module joy_db15_tx #(
    parameter int BITS    = 16,
    parameter int TIMEOUT = 65536
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] p1_btn,
    input  logic [BITS-1:0] p2_btn,
    input  logic            joy_load,
    input  logic            joy_clk,
    output logic            joy_data,
    output logic            frame_done,
    output logic            overrun,
    output logic            host_active
);

    localparam int FB = 2 * BITS;
    localparam int CW = $clog2(FB + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(FB);
    localparam logic [CW-1:0] CNT_LAST = CW'(FB - 1);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // [0],[1] synchronize, [2] is the delayed copy used for edge detection
    logic [2:0] ld_pipe;
    logic [2:0] ck_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_pipe <= '1;
            ck_pipe <= '1;
        end else begin
            ld_pipe <= {ld_pipe[1:0], joy_load};
            ck_pipe <= {ck_pipe[1:0], joy_clk};
        end
    end

    logic ld_s;
    logic ld_fall;
    logic ck_rise;

    assign ld_s    = ld_pipe[1];
    assign ld_fall = ld_pipe[2] & ~ld_pipe[1];
    assign ck_rise = ck_pipe[1] & ~ck_pipe[2];

    state_t          state, state_n;
    logic [FB-1:0]   sh, sh_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [WW-1:0]   wd, wd_n;
    logic            fd_n;
    logic            ovr_n;
    logic            jd_n;
    logic            timed_out;

    // Watchdog: a fresh load edge in this cycle overrides saturation
    always_comb begin
        if (ld_fall)
            wd_n = '0;
        else if (wd == WD_MAX)
            wd_n = wd;
        else
            wd_n = wd + 1'b1;
    end

    assign timed_out = (wd == WD_MAX) && !ld_fall;

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        fd_n    = 1'b0;
        ovr_n   = overrun;

        if (timed_out) begin
            state_n = IDLE;
        end else if (!ld_s) begin
            // Load is transparent and dominates any clock edge seen this cycle
            state_n = LOAD;
            sh_n    = {~p2_btn, ~p1_btn};
            cnt_n   = '0;
            ovr_n   = 1'b0;
        end else begin
            case (state)
                LOAD: state_n = SHIFT;
                SHIFT: begin
                    if (ck_rise) begin
                        sh_n  = {1'b1, sh[FB-1:1]};
                        cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            fd_n    = 1'b1;
                            state_n = DONE;
                        end
                    end
                end
                DONE: begin
                    if (ck_rise) begin
                        sh_n  = {1'b1, sh[FB-1:1]};
                        ovr_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        jd_n = (state_n == LOAD || state_n == SHIFT) ? sh_n[0] : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sh          <= '1;
            cnt         <= '0;
            wd          <= WD_MAX;
            joy_data    <= 1'b1;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            host_active <= 1'b0;
        end else begin
            state       <= state_n;
            sh          <= sh_n;
            cnt         <= cnt_n;
            wd          <= wd_n;
            joy_data    <= jd_n;
            frame_done  <= fd_n;
            overrun     <= ovr_n;
            host_active <= (wd_n < WD_MAX);
        end
    end

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: emulates a host, predicts the serial stream from the
// button inputs into a queue, and checks every sampled bit and status flag.
module tb_joy_db15_tx;

    localparam int BITS = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [BITS-1:0] p1_btn = '0;
    logic [BITS-1:0] p2_btn = '0;
    logic            joy_load = 1'b1;
    logic            joy_clk = 1'b0;
    logic            joy_data, frame_done, overrun, host_active;
    logic            wd_data, wd_fd, wd_ovr, wd_ha;

    int   total = 0;
    int   bad = 0;
    int   fd_pulses = 0;
    logic exp_q[$];

    joy_db15_tx #(.BITS(BITS)) dut (
        .clk(clk), .reset(reset), .p1_btn(p1_btn), .p2_btn(p2_btn),
        .joy_load(joy_load), .joy_clk(joy_clk), .joy_data(joy_data),
        .frame_done(frame_done), .overrun(overrun), .host_active(host_active)
    );

    joy_db15_tx #(.BITS(BITS), .TIMEOUT(64)) dut_wd (
        .clk(clk), .reset(reset), .p1_btn(p1_btn), .p2_btn(p2_btn),
        .joy_load(joy_load), .joy_clk(joy_clk), .joy_data(wd_data),
        .frame_done(wd_fd), .overrun(wd_ovr), .host_active(wd_ha)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (frame_done) fd_pulses++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        logic [2*BITS-1:0] f;
        f = {~p2_btn, ~p1_btn};
        for (int i = 0; i < 2*BITS; i++) exp_q.push_back(f[i]);
    endtask

    task automatic pop_chk(input string tag);
        logic e;
        if (exp_q.size() == 0) begin
            chk({tag, "_qempty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, joy_data, e);
        end
    endtask

    task automatic do_load();
        joy_load = 1'b0;
        tick(6);
        joy_load = 1'b1;
        tick(6);
    endtask

    // One host clock: rise, hold 6 clk, fall, hold 4; reports the cycle of frame_done
    task automatic clk_pulse(output int fd_at);
        fd_at = -1;
        joy_clk = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (frame_done && fd_at < 0) fd_at = k;
        end
        joy_clk = 1'b0;
        tick(4);
    endtask

    task automatic shift_frame(input string tag, input int rises, output int fd_last);
        int fa;
        fd_last = -1;
        for (int r = 1; r <= rises; r++) begin
            clk_pulse(fa);
            if (r < 2*BITS) pop_chk($sformatf("%s_b%0d", tag, r));
            if (r == 2*BITS) fd_last = fa;
        end
    endtask

    task automatic full_frame(input string tag);
        int fa;
        int f0;
        f0 = fd_pulses;
        push_frame();
        do_load();
        pop_chk({tag, "_b0"});
        shift_frame(tag, 2*BITS, fa);
        chk({tag, "_fd_lat"}, fa, 3);
        chk({tag, "_fd_cnt"}, fd_pulses - f0, 1);
        chk({tag, "_tail"}, joy_data, 1);
        chk({tag, "_ha"}, host_active, 1);
    endtask

    initial begin
        int fa, f0, seen, fall, rise;

        tick(3);
        chk("rst_data", joy_data, 1);
        chk("rst_fd", frame_done, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_ha", host_active, 0);
        reset = 1'b0;
        tick(2);

        p1_btn = 16'h0001; p2_btn = 16'h8000;
        full_frame("fa");

        p1_btn = 16'hA5A5; p2_btn = 16'h3C3C;
        full_frame("fb");

        // Abort after 10 shifts, then reload with new P1 buttons
        p1_btn = 16'h1234; p2_btn = 16'h5678;
        push_frame();
        do_load();
        pop_chk("ab_b0");
        for (int r = 1; r <= 10; r++) begin
            clk_pulse(fa);
            pop_chk($sformatf("ab_b%0d", r));
        end
        exp_q.delete();
        f0 = fd_pulses;
        p1_btn = 16'h0F0F;
        push_frame();
        do_load();
        chk("ab_nofd", fd_pulses - f0, 0);
        chk("ab_first", joy_data, 0);
        pop_chk("ab2_b0");
        shift_frame("ab2", 2*BITS, fa);
        chk("ab2_fd_lat", fa, 3);
        chk("ab2_fd_cnt", fd_pulses - f0, 1);

        // Overrun: a 33rd rise after the frame completes
        p1_btn = 16'h00FF; p2_btn = 16'hFF00;
        push_frame();
        do_load();
        pop_chk("ov_b0");
        shift_frame("ov", 2*BITS, fa);
        chk("ov_fd_lat", fa, 3);
        chk("ov_pre", overrun, 0);
        clk_pulse(fa);
        chk("ov_flag", overrun, 1);
        chk("ov_data", joy_data, 1);
        joy_load = 1'b0;
        tick(5);
        chk("ov_clr", overrun, 0);
        joy_load = 1'b1;
        tick(6);

        // Load and clock rise land in the same clk
        p1_btn = 16'hC33C; p2_btn = 16'h1FF8;
        push_frame();
        joy_load = 1'b0;
        joy_clk = 1'b1;
        tick(6);
        joy_clk = 1'b0;
        tick(4);
        joy_load = 1'b1;
        tick(6);
        pop_chk("sim_b0");
        f0 = fd_pulses;
        shift_frame("sim", 2*BITS, fa);
        chk("sim_fd_lat", fa, 3);
        chk("sim_fd_cnt", fd_pulses - f0, 1);

        // Watchdog on the TIMEOUT=64 instance
        p1_btn = 16'hFFFF; p2_btn = 16'hFFFF;
        seen = 0; fall = 0;
        joy_load = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (n == 6) joy_load = 1'b1;
            if (n == 20) chk("wd_pre_data", wd_data, 0);
            if (wd_ha) seen = 1;
            else if (seen != 0 && fall == 0) fall = n;
        end
        chk("wd_seen", seen, 1);
        chk("wd_fall", fall, 67);
        chk("wd_data", wd_data, 1);
        rise = 0;
        joy_load = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            if (wd_ha && rise == 0) rise = n;
        end
        chk("wd_rise", (rise >= 1 && rise <= 4) ? 1 : 0, 1);
        joy_load = 1'b1;
        tick(6);

        // Asynchronous reset mid-frame with a 0 on the line
        push_frame();
        do_load();
        pop_chk("rm_b0");
        for (int r = 1; r <= 5; r++) begin
            clk_pulse(fa);
            pop_chk($sformatf("rm_b%0d", r));
        end
        @(posedge clk);
        #5;
        reset = 1'b1;
        #1;
        chk("rm_data", joy_data, 1);
        chk("rm_fd", frame_done, 0);
        chk("rm_ovr", overrun, 0);
        chk("rm_ha", host_active, 0);
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
